// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if - handshake and payload bundle for the EX/MEM pipeline stage.
//   Upstream (EX) side : in_valid, in_ready, flush and the *_in payload/controls.
//   Downstream (MEM)   : out_valid, out_ready, the registered payload/controls.
//   stall_count        : saturating back-pressure cycle count.
// Modports: slave = the stage itself, master = the surrounding pipeline/bench.
interface ex_mem_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int MEMTOREG_W = 2,
  parameter int CNT_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [DATA_W-1:0]     ALUResult_in;
  logic [DATA_W-1:0]     registerFileDataB_in;
  logic [DATA_W-1:0]     pcpp_in;
  logic [REG_ADDR_W-1:0] registerFileWrite_in;
  logic [MEMTOREG_W-1:0] memToReg_in;
  logic                  memRead_in;
  logic                  memWrite_in;
  logic                  regWrite_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     ALUResult;
  logic [DATA_W-1:0]     registerFileDataB;
  logic [DATA_W-1:0]     pcpp;
  logic [REG_ADDR_W-1:0] registerFileWrite;
  logic [MEMTOREG_W-1:0] memToReg;
  logic                  memRead;
  logic                  memWrite;
  logic                  regWrite;
  logic [CNT_W-1:0]      stall_count;

  modport slave (
    input  in_valid, flush, ALUResult_in, registerFileDataB_in, pcpp_in,
           registerFileWrite_in, memToReg_in, memRead_in, memWrite_in,
           regWrite_in, out_ready,
    output in_ready, out_valid, ALUResult, registerFileDataB, pcpp,
           registerFileWrite, memToReg, memRead, memWrite, regWrite, stall_count
  );

  modport master (
    output in_valid, flush, ALUResult_in, registerFileDataB_in, pcpp_in,
           registerFileWrite_in, memToReg_in, memRead_in, memWrite_in,
           regWrite_in, out_ready,
    input  in_ready, out_valid, ALUResult, registerFileDataB, pcpp,
           registerFileWrite, memToReg, memRead, memWrite, regWrite, stall_count
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage - EX/MEM pipeline register with valid/ready handshake and a
// 2-entry skid buffer (main entry M drives outputs, skid entry S absorbs the
// one instruction accepted while MEM stalls). All state changes on the
// falling edge of clock; reset_n is asynchronous active-low.
// Ports:
//   clock   - stage clock (falling-edge active)
//   reset_n - asynchronous active-low reset
//   bus     - ex_mem_stage_if.slave: handshake, flush, payload in/out,
//             gated control strobes and the saturating stall counter.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int MEMTOREG_W = 2,
  parameter int CNT_W      = 16
) (
  input logic           clock,
  input logic           reset_n,
  ex_mem_stage_if.slave bus
);
  // Packed entry layout: {ALU, dataB, pcpp, rd, memToReg, memRead, memWrite, regWrite}
  localparam int PW = 3*DATA_W + REG_ADDR_W + MEMTOREG_W + 3;

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_m;
  logic [PW-1:0]    r_s;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [PW-1:0]    w_in_entry;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_entry = {bus.ALUResult_in, bus.registerFileDataB_in, bus.pcpp_in,
                       bus.registerFileWrite_in, bus.memToReg_in,
                       bus.memRead_in, bus.memWrite_in, bus.regWrite_in};

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_m         <= '0;
      r_s         <= '0;
      r_in_ready  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // Counts every edge on which MEM held off a valid instruction,
      // independent of flush.
      if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);

      if (bus.flush) begin
        // Payload in r_m is kept so outputs stay defined; strobes are gated
        // off by out_valid going low.
        r_state    <= EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            r_in_ready <= 1'b1;
            if (w_in_fire) begin
              r_m     <= w_in_entry;
              r_state <= HALF;
            end
          end
          HALF: begin
            if (w_in_fire && w_out_fire) begin
              r_m <= w_in_entry;
            end else if (w_out_fire) begin
              r_state <= EMPTY;
            end else if (w_in_fire) begin
              // MEM stalled: park the new instruction behind M.
              r_s        <= w_in_entry;
              r_state    <= FULL;
              r_in_ready <= 1'b0;
            end
          end
          FULL: begin
            // in_ready is low here, so only the drain path exists.
            if (w_out_fire) begin
              r_m        <= r_s;
              r_state    <= HALF;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready          = r_in_ready;
  assign bus.out_valid         = w_out_valid;
  assign bus.ALUResult         = r_m[PW-1 -: DATA_W];
  assign bus.registerFileDataB = r_m[PW-1-DATA_W -: DATA_W];
  assign bus.pcpp              = r_m[PW-1-2*DATA_W -: DATA_W];
  assign bus.registerFileWrite = r_m[MEMTOREG_W+3 +: REG_ADDR_W];
  assign bus.memToReg          = r_m[3 +: MEMTOREG_W];
  // Strobes must never fire on a bubble.
  assign bus.memRead           = r_m[2] & w_out_valid;
  assign bus.memWrite          = r_m[1] & w_out_valid;
  assign bus.regWrite          = r_m[0] & w_out_valid;
  assign bus.stall_count       = r_stall_cnt;
endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(4), .MEMTOREG_W(2), .CNT_W(16)) bus ();
  ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(4), .MEMTOREG_W(2), .CNT_W(3))  sbus ();

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(4), .MEMTOREG_W(2), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );
  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(4), .MEMTOREG_W(2), .CNT_W(3)) dut_sat (
    .clock(clock), .reset_n(reset_n), .bus(sbus.slave)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // One falling edge, then settle.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Drive one instruction on the main stage; side fields derive from alu.
  task automatic drive(input logic v, input logic [31:0] alu, input logic mr,
                       input logic mw, input logic rw, input logic ordy);
    bus.in_valid             = v;
    bus.ALUResult_in         = alu;
    bus.registerFileDataB_in = alu ^ 32'hFFFF_0000;
    bus.pcpp_in              = alu + 32'd1;
    bus.registerFileWrite_in = alu[3:0];
    bus.memToReg_in          = alu[1:0];
    bus.memRead_in           = mr;
    bus.memWrite_in          = mw;
    bus.regWrite_in          = rw;
    bus.out_ready            = ordy;
  endtask

  logic [31:0] exp_alu;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    sbus.in_valid = 1'b0; sbus.flush = 1'b0; sbus.out_ready = 1'b0;
    sbus.ALUResult_in = 32'h77; sbus.registerFileDataB_in = '0; sbus.pcpp_in = '0;
    sbus.registerFileWrite_in = '0; sbus.memToReg_in = '0;
    sbus.memRead_in = 1'b0; sbus.memWrite_in = 1'b0; sbus.regWrite_in = 1'b0;

    // Reset state
    #13;
    check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check_eq("rst_alu", {32'd0, bus.ALUResult}, 64'd0);
    check_eq("rst_stall", {48'd0, bus.stall_count}, 64'd0);
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Streaming: 4 back-to-back instructions with out_ready=1
    for (int k = 0; k < 4; k++) begin
      exp_alu = 32'h10 * (k + 1);
      drive(1'b1, exp_alu, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check_eq($sformatf("stream%0d_valid", k), {63'd0, bus.out_valid}, 64'd1);
      check_eq($sformatf("stream%0d_alu", k), {32'd0, bus.ALUResult}, {32'd0, exp_alu});
      check_eq($sformatf("stream%0d_in_ready", k), {63'd0, bus.in_ready}, 64'd1);
    end
    check_eq("stream_dataB", {32'd0, bus.registerFileDataB}, 64'hFFFF_0040);
    check_eq("stream_pcpp", {32'd0, bus.pcpp}, 64'h41);
    check_eq("stream_rd", {60'd0, bus.registerFileWrite}, 64'h0);
    check_eq("stream_regWrite", {63'd0, bus.regWrite}, 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("stream_drained", {63'd0, bus.out_valid}, 64'd0);
    check_eq("stream_stall", {48'd0, bus.stall_count}, 64'd0);

    // Back-pressure: 0xA, 0xB with out_ready=0, then 0xC held at input
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("bp_in_ready_full", {63'd0, bus.in_ready}, 64'd0);
    check_eq("bp_head_a", {32'd0, bus.ALUResult}, 64'hA);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("bp_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check_eq("bp_hold_a", {32'd0, bus.ALUResult}, 64'hA);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("bp_out_b", {32'd0, bus.ALUResult}, 64'hB);
    check_eq("bp_in_ready_half", {63'd0, bus.in_ready}, 64'd1);
    tick();
    check_eq("bp_out_c", {32'd0, bus.ALUResult}, 64'hC);
    check_eq("bp_c_valid", {63'd0, bus.out_valid}, 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("bp_drained", {63'd0, bus.out_valid}, 64'd0);
    check_eq("bp_stall", {48'd0, bus.stall_count}, 64'd2);

    // Flush while FULL, incoming memWrite instruction must be dropped
    drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("fl_full", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("fl_memWrite", {63'd0, bus.memWrite}, 64'd0);
    check_eq("fl_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check_eq("fl_alu_hold", {32'd0, bus.ALUResult}, 64'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("fl_no_emit", {63'd0, bus.out_valid}, 64'd0);
    check_eq("fl_stall_kept", {48'd0, bus.stall_count}, 64'd4);

    // Bubble gating
    drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("bub_memRead_on", {63'd0, bus.memRead}, 64'd1);
    check_eq("bub_regWrite_on", {63'd0, bus.regWrite}, 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("bub_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("bub_memRead_off", {63'd0, bus.memRead}, 64'd0);
    check_eq("bub_regWrite_off", {63'd0, bus.regWrite}, 64'd0);
    check_eq("bub_alu_hold", {32'd0, bus.ALUResult}, 64'h55);

    // Counter saturation on the CNT_W=3 instance
    sbus.in_valid = 1'b1;
    tick();
    sbus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_eq("sat_six", {61'd0, sbus.stall_count}, 64'd6);
    for (int k = 0; k < 4; k++) tick();
    check_eq("sat_seven", {61'd0, sbus.stall_count}, 64'd7);
    tick();
    tick();
    check_eq("sat_stays", {61'd0, sbus.stall_count}, 64'd7);

    // Async reset while FULL
    drive(1'b1, 32'h91, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h92, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("ar_full", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("ar_alu", {32'd0, bus.ALUResult}, 64'd0);
    check_eq("ar_memRead", {63'd0, bus.memRead}, 64'd0);
    check_eq("ar_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check_eq("ar_stall", {48'd0, bus.stall_count}, 64'd0);
    #3;
    reset_n = 1'b1;
    tick();
    check_eq("ar_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check_eq("ar_release_empty", {63'd0, bus.out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
